// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register pending-write counters for an in-order
// issue stage. It stalls on RAW (a source still has writes in flight) and on
// WAW saturation (the destination counter is full). Retire ports (writeback
// and squash) decrement the counters. With WB_BYPASS set, a register whose
// every outstanding write retires this cycle is treated as already free.
module hazard_scoreboard #(
  parameter int NREG      = 32,
  parameter int NRD       = 3,
  parameter int NRET      = 2,
  parameter int CNT_W     = 2,
  parameter int WB_BYPASS = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            issue_valid,
  input  logic                            issue_we,
  input  logic [$clog2(NREG)-1:0]         issue_dest,
  input  logic [NRD-1:0]                  src_valid,
  input  logic [NRD*$clog2(NREG)-1:0]     src_addr,
  input  logic [NRET-1:0]                 ret_valid,
  input  logic [NRET*$clog2(NREG)-1:0]    ret_dest,
  output logic                            issue_ready,
  output logic [NREG-1:0]                 busy_vec,
  output logic                            err_underflow
);

  localparam int LW = $clog2(NREG);
  // Wide enough for counter + increment and for the per-cycle retire count.
  localparam int SW = CNT_W + $clog2(NRET + 1) + 1;

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [NREG-1:0]  busy_q, busy_d;
  logic             err_q, err_d;

  logic [SW-1:0]    ret_hits [NREG];
  logic             raw_haz;
  logic             waw_haz;
  logic             accept;
  logic [SW-1:0]    tot;

  // Count how many retire ports name each register this cycle.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      ret_hits[i] = '0;
      for (int k = 0; k < NRET; k++) begin
        if (ret_valid[k] && (ret_dest[k*LW +: LW] == LW'(i)))
          ret_hits[i] = ret_hits[i] + SW'(1);
      end
    end
  end

  // Hazard detection and issue handshake; ready ignores issue_valid.
  always_comb begin
    raw_haz = 1'b0;
    for (int k = 0; k < NRD; k++) begin
      if (src_valid[k] && (src_addr[k*LW +: LW] != '0) &&
          (cnt_q[src_addr[k*LW +: LW]] != '0) &&
          !((WB_BYPASS != 0) &&
            (SW'(cnt_q[src_addr[k*LW +: LW]]) == ret_hits[src_addr[k*LW +: LW]])))
        raw_haz = 1'b1;
    end
    waw_haz     = issue_we && (issue_dest != '0) && (&cnt_q[issue_dest]);
    issue_ready = ~(raw_haz | waw_haz);
    accept      = issue_valid & issue_ready;
  end

  // Net counter update: +1 for an accepted write, -1 per naming retire port,
  // clamped at zero with a sticky underflow flag. r0 never counts.
  always_comb begin
    err_d = err_q;
    tot   = '0;
    for (int i = 0; i < NREG; i++) begin
      tot = SW'(cnt_q[i]) +
            SW'(accept && issue_we && (issue_dest == LW'(i)));
      if (i == 0) begin
        cnt_d[i] = '0;
      end else if (ret_hits[i] > tot) begin
        cnt_d[i] = '0;
        err_d    = 1'b1;
      end else begin
        cnt_d[i] = CNT_W'(tot - ret_hits[i]);
      end
      busy_d[i] = (cnt_d[i] != '0);
    end
  end

  // State registers; reset wins over any same-cycle issue or retire.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign busy_vec      = busy_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard. Two instances share the stimulus:
// dut (no bypass) and dut_bp (WB_BYPASS=1).
module tb_hazard_scoreboard;

  localparam int NREG = 32;
  localparam int NRD  = 3;
  localparam int NRET = 2;
  localparam int LW   = 5;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 issue_valid, issue_we;
  logic [LW-1:0]        issue_dest;
  logic [NRD-1:0]       src_valid;
  logic [NRD*LW-1:0]    src_addr;
  logic [NRET-1:0]      ret_valid;
  logic [NRET*LW-1:0]   ret_dest;
  logic                 issue_ready, issue_ready_bp;
  logic [NREG-1:0]      busy_vec, busy_vec_bp;
  logic                 err_underflow, err_underflow_bp;

  int vectors   = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.NREG(NREG), .NRD(NRD), .NRET(NRET), .CNT_W(2), .WB_BYPASS(0)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_we(issue_we),
    .issue_dest(issue_dest), .src_valid(src_valid), .src_addr(src_addr),
    .ret_valid(ret_valid), .ret_dest(ret_dest), .issue_ready(issue_ready),
    .busy_vec(busy_vec), .err_underflow(err_underflow));

  hazard_scoreboard #(.NREG(NREG), .NRD(NRD), .NRET(NRET), .CNT_W(2), .WB_BYPASS(1)) dut_bp (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_we(issue_we),
    .issue_dest(issue_dest), .src_valid(src_valid), .src_addr(src_addr),
    .ret_valid(ret_valid), .ret_dest(ret_dest), .issue_ready(issue_ready_bp),
    .busy_vec(busy_vec_bp), .err_underflow(err_underflow_bp));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_we = 1'b0; issue_dest = '0;
    src_valid = '0; src_addr = '0; ret_valid = '0; ret_dest = '0;
  endtask

  task automatic do_issue(input logic [LW-1:0] d);
    idle();
    issue_valid = 1'b1; issue_we = 1'b1; issue_dest = d;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    vectors++; if (busy_vec !== 32'h0) begin miscompares++; $display("FAIL reset_busy got=%h exp=%h", busy_vec, 32'h0); end
    vectors++; if (err_underflow !== 1'b0) begin miscompares++; $display("FAIL reset_err got=%b exp=0", err_underflow); end
    src_valid = 3'b001; src_addr = {5'd0, 5'd0, 5'd5};
    #1;
    vectors++; if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got=%b exp=1", issue_ready); end
    idle();
  endtask

  task automatic test_raw();
    do_issue(5'd5);
    #1;
    vectors++; if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL raw_first_issue got=%b exp=1", issue_ready); end
    tick();
    idle();
    #1;
    vectors++; if (busy_vec !== 32'h0000_0020) begin miscompares++; $display("FAIL raw_busy5 got=%h exp=%h", busy_vec, 32'h0000_0020); end
    // Stalled issue to r5 reading r5 must not be accepted.
    issue_valid = 1'b1; issue_we = 1'b1; issue_dest = 5'd5;
    src_valid = 3'b001; src_addr = {5'd0, 5'd0, 5'd5};
    #1;
    vectors++; if (issue_ready !== 1'b0) begin miscompares++; $display("FAIL raw_port0 got=%b exp=0", issue_ready); end
    tick();
    idle();
    src_valid = 3'b100; src_addr = {5'd5, 5'd0, 5'd0};
    #1;
    vectors++; if (issue_ready !== 1'b0) begin miscompares++; $display("FAIL raw_port2 got=%b exp=0", issue_ready); end
    src_valid = 3'b011;
    #1;
    vectors++; if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL raw_src_invalid got=%b exp=1", issue_ready); end
    src_valid = 3'b111; src_addr = {5'd0, 5'd0, 5'd0};
    #1;
    vectors++; if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL raw_r0 got=%b exp=1", issue_ready); end
    idle();
    ret_valid = 2'b01; ret_dest = {5'd0, 5'd5};
    tick();
    idle();
    src_valid = 3'b001; src_addr = {5'd0, 5'd0, 5'd5};
    #1;
    vectors++; if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL raw_after_retire got=%b exp=1", issue_ready); end
    vectors++; if (busy_vec !== 32'h0) begin miscompares++; $display("FAIL raw_busy_clear got=%h exp=%h", busy_vec, 32'h0); end
    vectors++; if (err_underflow !== 1'b0) begin miscompares++; $display("FAIL raw_no_err got=%b exp=0", err_underflow); end
    idle();
  endtask

  task automatic test_bypass();
    do_reset();
    do_issue(5'd7);
    tick();
    idle();
    src_valid = 3'b001; src_addr = {5'd0, 5'd0, 5'd7};
    ret_valid = 2'b01; ret_dest = {5'd0, 5'd7};
    #1;
    vectors++; if (issue_ready_bp !== 1'b1) begin miscompares++; $display("FAIL bypass_on got=%b exp=1", issue_ready_bp); end
    vectors++; if (issue_ready !== 1'b0) begin miscompares++; $display("FAIL bypass_off got=%b exp=0", issue_ready); end
    tick();
    idle();
    vectors++; if (busy_vec_bp !== 32'h0) begin miscompares++; $display("FAIL bypass_busy got=%h exp=%h", busy_vec_bp, 32'h0); end
  endtask

  task automatic test_waw();
    do_reset();
    for (int n = 0; n < 3; n++) begin
      do_issue(5'd9);
      #1;
      vectors++; if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL waw_fill%0d got=%b exp=1", n, issue_ready); end
      tick();
    end
    do_issue(5'd9);
    #1;
    vectors++; if (issue_ready !== 1'b0) begin miscompares++; $display("FAIL waw_saturated got=%b exp=0", issue_ready); end
    issue_we = 1'b0;
    #1;
    vectors++; if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL waw_no_we got=%b exp=1", issue_ready); end
    idle();
    ret_valid = 2'b01; ret_dest = {5'd0, 5'd9};
    tick();
    do_issue(5'd9);
    #1;
    vectors++; if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL waw_after_retire got=%b exp=1", issue_ready); end
    tick();
    // Counter back at 3: two ports retire together, then one more.
    idle();
    ret_valid = 2'b11; ret_dest = {5'd9, 5'd9};
    tick();
    idle();
    vectors++; if (busy_vec[9] !== 1'b1) begin miscompares++; $display("FAIL waw_dual_retire got=%b exp=1", busy_vec[9]); end
    ret_valid = 2'b10; ret_dest = {5'd9, 5'd0};
    tick();
    idle();
    vectors++; if (busy_vec[9] !== 1'b0) begin miscompares++; $display("FAIL waw_drained got=%b exp=0", busy_vec[9]); end
    vectors++; if (err_underflow !== 1'b0) begin miscompares++; $display("FAIL waw_no_err got=%b exp=0", err_underflow); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    do_issue(5'd3);
    tick();
    do_issue(5'd3);
    ret_valid = 2'b01; ret_dest = {5'd0, 5'd3};
    #1;
    vectors++; if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready got=%b exp=1", issue_ready); end
    tick();
    idle();
    vectors++; if (busy_vec !== 32'h0000_0008) begin miscompares++; $display("FAIL b2b_net_zero got=%h exp=%h", busy_vec, 32'h0000_0008); end
    ret_valid = 2'b01; ret_dest = {5'd0, 5'd3};
    tick();
    idle();
    vectors++; if (busy_vec[3] !== 1'b0) begin miscompares++; $display("FAIL b2b_drain got=%b exp=0", busy_vec[3]); end
    vectors++; if (err_underflow !== 1'b0) begin miscompares++; $display("FAIL b2b_no_err got=%b exp=0", err_underflow); end
  endtask

  task automatic test_r0();
    do_reset();
    do_issue(5'd0);
    ret_valid = 2'b11; ret_dest = {5'd0, 5'd0};
    tick();
    idle();
    vectors++; if (err_underflow !== 1'b0) begin miscompares++; $display("FAIL r0_err got=%b exp=0", err_underflow); end
    vectors++; if (busy_vec !== 32'h0) begin miscompares++; $display("FAIL r0_busy got=%h exp=%h", busy_vec, 32'h0); end
  endtask

  task automatic test_underflow();
    do_reset();
    ret_valid = 2'b01; ret_dest = {5'd0, 5'd12};
    tick();
    idle();
    vectors++; if (err_underflow !== 1'b1) begin miscompares++; $display("FAIL uf_set got=%b exp=1", err_underflow); end
    vectors++; if (busy_vec[12] !== 1'b0) begin miscompares++; $display("FAIL uf_clamp got=%b exp=0", busy_vec[12]); end
    tick();
    tick();
    vectors++; if (err_underflow !== 1'b1) begin miscompares++; $display("FAIL uf_sticky got=%b exp=1", err_underflow); end
    do_reset();
    vectors++; if (err_underflow !== 1'b0) begin miscompares++; $display("FAIL uf_reset got=%b exp=0", err_underflow); end
  endtask

  task automatic test_reset_priority();
    do_reset();
    do_issue(5'd4);
    tick();
    do_issue(5'd6);
    tick();
    do_issue(5'd4);
    ret_valid = 2'b01; ret_dest = {5'd0, 5'd20};
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    src_valid = 3'b011; src_addr = {5'd0, 5'd6, 5'd4};
    #1;
    vectors++; if (busy_vec !== 32'h0) begin miscompares++; $display("FAIL rp_busy got=%h exp=%h", busy_vec, 32'h0); end
    vectors++; if (issue_ready !== 1'b1) begin miscompares++; $display("FAIL rp_ready got=%b exp=1", issue_ready); end
    vectors++; if (err_underflow !== 1'b0) begin miscompares++; $display("FAIL rp_err got=%b exp=0", err_underflow); end
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    test_reset();
    test_raw();
    test_bypass();
    test_waw();
    test_back_to_back();
    test_r0();
    test_underflow();
    test_reset_priority();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
